// File: rtl/win_scanner.sv
// Connect-four board scanner: walks every horizontal, vertical and diagonal line,
// streaming cells into an external four-in-a-row recognizer and latching the first win.
module win_scanner (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic [2:0] board_row,
  output logic [2:0] board_col,
  input  logic [1:0] board_piece,
  output logic [1:0] rec_piece,
  output logic       rec_step,
  output logic       rec_clear_n,
  input  logic [1:0] rec_out,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner,
  output logic [1:0] win_dir
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR_A, S_CLEAR_B, S_FETCH, S_STEP, S_CHECK, S_DONE
  } state_e;

  localparam logic [1:0] DIR_H  = 2'd0;
  localparam logic [1:0] DIR_V  = 2'd1;
  localparam logic [1:0] DIR_UR = 2'd2;
  localparam logic [1:0] DIR_UL = 2'd3;
  localparam logic [2:0] ROW_TOP   = 3'd5;
  localparam logic [2:0] COL_RIGHT = 3'd6;

  state_e     state_q, state_d;
  logic [1:0] dir_q, dir_d;
  logic [2:0] row_q, row_d, col_q, col_d;
  logic [2:0] srow_q, srow_d, scol_q, scol_d;
  logic [1:0] rec_piece_q, rec_piece_d;
  logic       rec_step_q, rec_step_d;
  logic       rec_clear_n_q, rec_clear_n_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic [1:0] winner_q, winner_d, win_dir_q, win_dir_d;

  logic       line_end, last_line;
  logic [2:0] nxt_row, nxt_col;
  logic [1:0] nl_dir;
  logic [2:0] nl_srow, nl_scol;

  // Next cell along the current line, and whether the walk falls off the board.
  always_comb begin
    nxt_row  = row_q;
    nxt_col  = col_q;
    line_end = 1'b0;
    unique case (dir_q)
      DIR_H: begin
        nxt_col  = col_q + 3'd1;
        line_end = (col_q == COL_RIGHT);
      end
      DIR_V: begin
        nxt_row  = row_q + 3'd1;
        line_end = (row_q == ROW_TOP);
      end
      DIR_UR: begin
        nxt_row  = row_q + 3'd1;
        nxt_col  = col_q + 3'd1;
        line_end = (row_q == ROW_TOP) || (col_q == COL_RIGHT);
      end
      default: begin
        nxt_row  = row_q + 3'd1;
        nxt_col  = col_q - 3'd1;
        line_end = (row_q == ROW_TOP) || (col_q == 3'd0);
      end
    endcase
  end

  // Start cell of the following line; diagonals sweep the bottom row, then one side column.
  always_comb begin
    nl_dir    = dir_q;
    nl_srow   = srow_q;
    nl_scol   = scol_q;
    last_line = 1'b0;
    unique case (dir_q)
      DIR_H: begin
        if (srow_q == ROW_TOP) begin
          nl_dir  = DIR_V;
          nl_srow = 3'd0;
          nl_scol = 3'd0;
        end else begin
          nl_srow = srow_q + 3'd1;
        end
      end
      DIR_V: begin
        if (scol_q == COL_RIGHT) begin
          nl_dir  = DIR_UR;
          nl_srow = 3'd0;
          nl_scol = 3'd0;
        end else begin
          nl_scol = scol_q + 3'd1;
        end
      end
      DIR_UR: begin
        if (srow_q == 3'd0 && scol_q != COL_RIGHT) begin
          nl_scol = scol_q + 3'd1;
        end else if (srow_q == 3'd0) begin
          nl_srow = 3'd1;
          nl_scol = 3'd0;
        end else if (srow_q != ROW_TOP) begin
          nl_srow = srow_q + 3'd1;
        end else begin
          nl_dir  = DIR_UL;
          nl_srow = 3'd0;
          nl_scol = 3'd0;
        end
      end
      default: begin
        if (srow_q == 3'd0 && scol_q != COL_RIGHT) begin
          nl_scol = scol_q + 3'd1;
        end else if (srow_q == 3'd0) begin
          nl_srow = 3'd1;
          nl_scol = COL_RIGHT;
        end else if (srow_q != ROW_TOP) begin
          nl_srow = srow_q + 3'd1;
        end else begin
          last_line = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    row_d       = row_q;
    col_d       = col_q;
    srow_d      = srow_q;
    scol_d      = scol_q;
    rec_piece_d = rec_piece_q;
    winner_d    = winner_q;
    win_dir_d   = win_dir_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CLEAR_A;
          winner_d  = 2'b00;
          win_dir_d = 2'b00;
          dir_d     = DIR_H;
          srow_d    = 3'd0;
          scol_d    = 3'd0;
          row_d     = 3'd0;
          col_d     = 3'd0;
        end
      end
      S_CLEAR_A: state_d = S_CLEAR_B;
      S_CLEAR_B: state_d = S_FETCH;
      S_FETCH: begin
        state_d     = S_STEP;
        rec_piece_d = (board_piece == 2'b11) ? 2'b00 : board_piece;
      end
      S_STEP: state_d = S_CHECK;
      S_CHECK: begin
        if (rec_out != 2'b00) begin
          state_d   = S_DONE;
          winner_d  = rec_out;
          win_dir_d = dir_q;
        end else if (!line_end) begin
          state_d = S_FETCH;
          row_d   = nxt_row;
          col_d   = nxt_col;
        end else if (last_line) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CLEAR_A;
          dir_d   = nl_dir;
          srow_d  = nl_srow;
          scol_d  = nl_scol;
          row_d   = nl_srow;
          col_d   = nl_scol;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        row_d   = 3'd0;
        col_d   = 3'd0;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs decoded from the next state so they leave flops cleanly.
    rec_clear_n_d = !(state_d == S_CLEAR_A || state_d == S_CLEAR_B);
    rec_step_d    = (state_d == S_CLEAR_B) || (state_d == S_STEP);
    busy_d        = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d        = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      dir_q         <= DIR_H;
      row_q         <= 3'd0;
      col_q         <= 3'd0;
      srow_q        <= 3'd0;
      scol_q        <= 3'd0;
      rec_piece_q   <= 2'b00;
      rec_step_q    <= 1'b0;
      rec_clear_n_q <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      winner_q      <= 2'b00;
      win_dir_q     <= 2'b00;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      row_q         <= row_d;
      col_q         <= col_d;
      srow_q        <= srow_d;
      scol_q        <= scol_d;
      rec_piece_q   <= rec_piece_d;
      rec_step_q    <= rec_step_d;
      rec_clear_n_q <= rec_clear_n_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      winner_q      <= winner_d;
      win_dir_q     <= win_dir_d;
    end
  end

  assign board_row   = row_q;
  assign board_col   = col_q;
  assign rec_piece   = rec_piece_q;
  assign rec_step    = rec_step_q;
  assign rec_clear_n = rec_clear_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign winner      = winner_q;
  assign win_dir     = win_dir_q;

endmodule

// File: tb/tb_win_scanner.sv
// Directed bench for win_scanner with a board memory and a behavioural four-in-a-row recognizer.
module tb_win_scanner;

  logic       clock = 1'b0;
  logic       reset, start;
  logic [2:0] board_row, board_col;
  logic [1:0] board_piece, rec_piece, rec_out;
  logic       rec_step, rec_clear_n, busy, done;
  logic [1:0] winner, win_dir;

  logic [1:0] board [0:5][0:6];
  int vectors = 0;
  int fails   = 0;

  always #5 clock = ~clock;

  assign board_piece = (board_row < 3'd6 && board_col < 3'd7) ? board[board_row][board_col] : 2'b00;

  // Recognizer: run of four equal non-empty pieces latches that piece on rec_out.
  logic [1:0] m_last = 2'b00;
  int         m_cnt  = 0;
  logic [1:0] m_out  = 2'b00;
  assign rec_out = m_out;
  always @(posedge rec_step) begin
    if (!rec_clear_n) begin
      m_cnt <= 0; m_last <= 2'b00; m_out <= 2'b00;
    end else if (rec_piece == 2'b00) begin
      m_cnt <= 0; m_last <= 2'b00;
    end else if (rec_piece == m_last) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 >= 4) m_out <= m_last;
    end else begin
      m_last <= rec_piece; m_cnt <= 1;
    end
  end

  win_scanner dut (
    .clock(clock), .reset(reset), .start(start),
    .board_row(board_row), .board_col(board_col), .board_piece(board_piece),
    .rec_piece(rec_piece), .rec_step(rec_step), .rec_clear_n(rec_clear_n),
    .rec_out(rec_out), .busy(busy), .done(done),
    .winner(winner), .win_dir(win_dir)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_board();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        board[r][c] = 2'b00;
  endtask

  // Pulse start, then follow the scan; len = edges after the start edge until done shows.
  task automatic run_scan(input bit poke, output int len, output int busy_cnt, output logic [5:0] cell13);
    int n;
    bit seen;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    n = 0; busy_cnt = 0; seen = 1'b0; len = -1; cell13 = 6'd0;
    while (n < 1000 && !seen) begin
      @(negedge clock);
      start = (poke && n == 50) ? 1'b1 : 1'b0;
      if (n == 0) chk("winner_cleared_on_start", 32'(winner), 0);
      if (n == 13) cell13 = {board_row, board_col};
      if (done) begin
        seen = 1'b1; len = n;
      end else begin
        busy_cnt += int'(busy); n++;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 1);
    @(negedge clock);
    chk("done_one_cycle", 32'({busy, done}), 0);
  endtask

  initial begin
    int len, bcnt, dcnt;
    logic [5:0] c13;
    reset = 1'b0; start = 1'b0;
    clear_board();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy_done", 32'({busy, done}), 0);
    chk("rst_winner_dir", 32'({winner, win_dir}), 0);
    chk("rst_rec", 32'({rec_piece, rec_step, rec_clear_n}), 1);
    chk("rst_cell", 32'({board_row, board_col}), 0);
    reset = 1'b1;

    // empty board: full scan
    run_scan(1'b0, len, bcnt, c13);
    chk("empty_len", 32'(len), 578);
    chk("empty_busy", 32'(bcnt), 578);
    chk("empty_winner", 32'({winner, win_dir}), 0);

    // red row 0 cols 0-3
    board[0][0] = 2'b01; board[0][1] = 2'b01; board[0][2] = 2'b01; board[0][3] = 2'b01;
    run_scan(1'b0, len, bcnt, c13);
    chk("hrow_len", 32'(len), 14);
    chk("hrow_cell13", 32'(c13), 32'h03);
    chk("hrow_winner", 32'(winner), 1);
    chk("hrow_dir", 32'(win_dir), 0);
    repeat (5) @(negedge clock);
    chk("hrow_hold", 32'({winner, win_dir}), 32'h4);

    // yellow col 2 rows 0-3
    clear_board();
    for (int r = 0; r < 4; r++) board[r][2] = 2'b10;
    run_scan(1'b0, len, bcnt, c13);
    chk("vcol_len", 32'(len), 192);
    chk("vcol_winner", 32'(winner), 2);
    chk("vcol_dir", 32'(win_dir), 1);

    // red up-right diagonal from (0,0)
    clear_board();
    for (int i = 0; i < 4; i++) board[i][i] = 2'b01;
    run_scan(1'b0, len, bcnt, c13);
    chk("ur_len", 32'(len), 292);
    chk("ur_winner", 32'(winner), 1);
    chk("ur_dir", 32'(win_dir), 2);

    // red up-left diagonal from (0,6)
    clear_board();
    for (int i = 0; i < 4; i++) board[i][6-i] = 2'b01;
    run_scan(1'b0, len, bcnt, c13);
    chk("ul_len", 32'(len), 517);
    chk("ul_winner", 32'(winner), 1);
    chk("ul_dir", 32'(win_dir), 3);

    // broken run: R R R Y R
    clear_board();
    board[0][0] = 2'b01; board[0][1] = 2'b01; board[0][2] = 2'b01;
    board[0][3] = 2'b10; board[0][4] = 2'b01;
    run_scan(1'b0, len, bcnt, c13);
    chk("nowin_len", 32'(len), 578);
    chk("nowin_winner", 32'({winner, win_dir}), 0);

    // code 11 everywhere in row 0 must read as empty
    clear_board();
    for (int c = 0; c < 7; c++) board[0][c] = 2'b11;
    run_scan(1'b0, len, bcnt, c13);
    chk("code11_len", 32'(len), 578);
    chk("code11_winner", 32'({winner, win_dir}), 0);

    // start pulsed mid-scan is ignored
    clear_board();
    run_scan(1'b1, len, bcnt, c13);
    chk("poke_len", 32'(len), 578);

    // reset at cycle 200 aborts without done
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    dcnt = 0;
    for (int n = 0; n <= 200; n++) begin
      @(negedge clock);
      dcnt += int'(done);
    end
    reset = 1'b0;
    @(negedge clock);
    chk("abort_busy_done", 32'({busy, done}), 0);
    chk("abort_rec", 32'({rec_piece, rec_step, rec_clear_n}), 1);
    chk("abort_cell", 32'({board_row, board_col}), 0);
    reset = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      dcnt += int'(done);
    end
    chk("abort_no_done", 32'(dcnt), 0);
    run_scan(1'b0, len, bcnt, c13);
    chk("restart_len", 32'(len), 578);
    chk("restart_busy", 32'(bcnt), 578);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/win_scanner.md
WIN_SCANNER -- requirements
Module: win_scanner

Interface
REQ-001 SHALL have port: clock  in  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  in  1  reset, synchronous and active-low (one clock; reset is synchronous and active-low).
REQ-003 SHALL have port: start  in  1  request a full board scan; sampled only in IDLE.
REQ-004 SHALL have port: board_row  out  3  row address of cell being read, 0 = bottom .. 5 = top.
REQ-005 SHALL have port: board_col  out  3  column address, 0 = left .. 6 = right.
REQ-006 SHALL have port: board_piece  in  2  piece at (board_row, board_col), combinational read: 00 empty, 01 red, 10 yellow, 11 treated as empty.
REQ-007 SHALL have port: rec_piece  out  2  registered piece presented to the four-in-a-row recognizer.
REQ-008 SHALL have port: rec_step  out  1  registered strobe driving the recognizer's advance input; rising edge = consume rec_piece.
REQ-009 SHALL have port: rec_clear_n  out  1  registered active-low synchronous clear to the recognizer, effective on a rec_step rise.
REQ-010 SHALL have port: rec_out  in  2  recognizer result: 00 none, 01 red four, 10 yellow four.
REQ-011 SHALL have port: busy  out  1  high in every state except IDLE and DONE.
REQ-012 SHALL have port: done  out  1  one-cycle pulse when a scan ends.
REQ-013 SHALL have port: winner  out  2  result of last scan: 00 none, 01 red, 10 yellow.
REQ-014 SHALL have port: win_dir  out  2  direction of the winning line: 00 horizontal, 01 vertical, 10 up-right, 11 up-left; 00 when winner = 00.

Function
REQ-015 SHALL implement states IDLE, CLEAR_A, CLEAR_B, FETCH, STEP, CHECK, DONE.
REQ-016 SHALL move IDLE -> CLEAR_A on the edge where start = 1, set winner = 00 and win_dir = 00, and select the first line; start outside IDLE is ignored.
REQ-017 CLEAR_A: rec_clear_n = 0, rec_step = 0. CLEAR_B: rec_clear_n = 0, rec_step = 1. Then -> FETCH.
REQ-018 FETCH: board_row/board_col = current cell, rec_clear_n = 1, rec_step = 0; on exit, rec_piece <= board_piece. -> STEP.
REQ-019 STEP: rec_step = 1 with rec_piece held stable. -> CHECK.
REQ-020 CHECK: rec_step = 0; if rec_out != 00, latch winner = rec_out and win_dir = current direction, -> DONE. Otherwise advance: next cell of line -> FETCH; line exhausted -> next line's CLEAR_A; last cell of last line -> DONE.
REQ-021 Line order: horizontal rows 0..5, each col 0->6. Vertical cols 0..6, each row 0->5. Up-right starts (0,0)..(0,6), then (1,0)..(5,0), step row+1/col+1. Up-left starts (0,0)..(0,6), then (1,6)..(5,6), step row+1/col-1. Walk until off-board.
REQ-022 Totals: 37 lines (including diagonals shorter than 4) and 168 cell visits; full scan = 37x2 + 168x3 = 578 cycles from CLEAR_A to last CHECK.
REQ-023 DONE: done = 1 for exactly one cycle -> IDLE. winner and win_dir hold until the next accepted start.
REQ-024 rec_step, rec_clear_n and rec_piece SHALL be driven from registers only, glitch-free.
REQ-025 board_row/board_col SHALL hold the current cell in every state, 0/0 in IDLE.

Reset
REQ-026 On a clock edge with reset = 0, from any state, SHALL enter IDLE with rec_piece = 00, rec_step = 0, rec_clear_n = 1, busy = 0, done = 0, winner = 00, win_dir = 00, board_row = 0, board_col = 0.
REQ-027 Reset mid-scan SHALL abort without asserting done; the next scan starts with a recognizer clear.

Verification
REQ-028 Empty board, start at edge k -> done high only in the cycle after edge k+578, winner = 00, busy high after edges k..k+577.
REQ-029 Red at row 0, cols 0-3, start at edge k -> CHECK of (0,3) after edge k+13, done after edge k+14, winner = 01, win_dir = 00.
REQ-030 Yellow at col 2, rows 0-3, rest empty -> winner = 10, win_dir = 01; red at (0,0),(1,1),(2,2),(3,3) -> winner = 01, win_dir = 10.
REQ-031 Red at row 0 cols 0,1,2,4 with yellow at col 3 -> no false win, full 578-cycle scan, winner = 00.
REQ-032 Reset low at cycle 200 of a scan -> IDLE next edge, no done pulse; restart then completes normally. Start pulsed while busy -> ignored, scan length unchanged.
